seq_divider16: RTL

Sequential restoring unsigned divider for the 16-bit ALU datapath. It accepts a dividend and divisor on a one-cycle start strobe and produces one quotient bit per clock. It returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse. It is the iterative counterpart to the combinational add/multiply paths and sits beside them behind the ALU result mux.

---
 rtl/seq_divider16_pkg.sv | 15 +
 rtl/seq_divider16_div_step.sv | 29 ++
 rtl/seq_divider16.sv | 103 ++++++++++
 3 files changed

// File: rtl/seq_divider16_pkg.sv
// Shared ALU package: divider state encoding, datapath width and the
// quotient value reported for a zero divisor.
package seq_divider16_pkg;

  localparam int DIV_WIDTH = 16;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider16_div_step.sv
// One restoring-division step: WIDTH+1-bit trial subtraction built as a ripple
// of full-adder cells (inverted divisor, carry-in 1), plus the quotient bit.
module seq_divider16_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   i_partial,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_trial,
  output logic             o_q_bit
);

  logic [WIDTH:0] w_b;
  logic [WIDTH:0] w_carry;

  assign w_b        = ~{1'b0, i_divisor};
  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign o_trial[i] = i_partial[i] ^ w_b[i] ^ w_carry[i];
    if (i < WIDTH) begin : g_carry
      assign w_carry[i+1] = (i_partial[i] & w_b[i]) |
                            (w_carry[i] & (i_partial[i] ^ w_b[i]));
    end
  end

  // A clear sign bit means the trial difference is non-negative.
  assign o_q_bit = ~o_trial[WIDTH];

endmodule

// File: rtl/seq_divider16.sv
// Sequential restoring unsigned divider: one quotient bit per clock, with a
// one-cycle done pulse and a divide-by-zero short path straight to DONE.
module seq_divider16
  import seq_divider16_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_e       r_state;
  div_state_e       w_next_state;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic             r_dbz;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_partial;
  logic [WIDTH:0]   w_trial;
  logic             w_q_bit;

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_count == CW'(WIDTH - 1));

  // The kept remainder is always below the divisor, so WIDTH bits hold it;
  // only the shifted value needs the extra bit.
  assign w_partial = {r_rem, r_q[WIDTH-1]};

  seq_divider16_div_step #(.WIDTH(WIDTH)) u_div_step (
    .i_partial (w_partial),
    .i_divisor (r_div),
    .o_trial   (w_trial),
    .o_q_bit   (w_q_bit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: defaulting every always_comb output first keeps the block latch-free.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = (divisor == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN:  begin
        if (w_last) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments here so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_count <= '0;
      r_div   <= divisor;
      if (divisor == '0) begin
        r_q   <= WIDTH'(DIV_ZERO_QUOTIENT);
        r_rem <= dividend;
        r_dbz <= 1'b1;
      end else begin
        r_q   <= dividend;
        r_rem <= '0;
        r_dbz <= 1'b0;
      end
    end else if (r_state == ST_RUN) begin
      r_count <= r_count + CW'(1);
      r_q     <= {r_q[WIDTH-2:0], w_q_bit};
      r_rem   <= w_q_bit ? w_trial[WIDTH-1:0] : w_partial[WIDTH-1:0];
    end
  end

  assign busy        = (r_state == ST_RUN);
  assign done        = (r_state == ST_DONE);
  assign quotient    = r_q;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule
